smc_seq: RTL and testbench
==========================

SMC_SEQ -- requirements
Module: smc_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: marks a valid transistor sample this cycle.
REQ-004 SHALL have port mode, input, 2 bits: bit0 1=drain current (Id), 0=transconductance (gm); bit1 1=largest three, 0=smallest three. Sampled only with the first sample of a set.
REQ-005 SHALL have port W, input, 3 bits: width of the current sample.
REQ-006 SHALL have port V_GS, input, 3 bits: gate-source voltage of the current sample.
REQ-007 SHALL have port V_DS, input, 3 bits: drain-source voltage of the current sample.
REQ-008 SHALL have port out_valid, output, 1 bit: result valid, one-cycle pulse.
REQ-009 SHALL have port out_n, output, 8 bits: result value; 0 whenever out_valid=0.

Function
REQ-010 SHALL run an FSM with states IDLE, COLLECT and OUT.
- IDLE->COLLECT on the first in_valid=1 sampled in IDLE.
- COLLECT->OUT after the 6th sample.
- OUT->IDLE after one cycle.
REQ-011 SHALL accept one set as exactly 6 samples on consecutive in_valid cycles; the sample count is 3 bits (0..5).
REQ-012 SHALL compute per sample Vov=V_GS-1.
- V_GS<=1: cutoff, value 0 (no wrap-around).
REQ-013 SHALL pick the region per sample.
- Triode if V_DS<Vov: Id=floor(W*V_DS*(2*Vov-V_DS)/3); gm=floor(2*W*V_DS/3).
- Saturation otherwise: Id=floor(W*Vov*Vov/3); gm=floor(2*W*Vov/3).
REQ-014 SHALL hold each per-sample value in 7 bits (max Id 84, max gm 28); intermediate products need at least 9 bits.
REQ-015 SHALL insert each value into a 6-entry descending sorted register array in the same cycle the sample is accepted. Ties may be in any order; the result is unaffected.
REQ-016 SHALL select three values a>=b>=c.
- mode[1]=1: entries 0..2.
- mode[1]=0: entries 3..5.
REQ-017 SHALL produce the output in OUT.
- Id: out_n=floor((3a+4b+5c)/12).
- gm: out_n=floor((a+b+c)/3).
- Use an unsigned sum of at least 10 bits.
REQ-018 SHALL assert out_valid=1 for exactly one cycle, starting at the rising edge after the edge that captures the 6th sample (latency 1 cycle).
REQ-019 SHALL abort an incomplete set when in_valid falls in COLLECT after 1..5 samples: discard the partial set, return to IDLE, produce no out_valid.
REQ-020 SHALL ignore in_valid in OUT, and any in_valid held past 6 samples. A new set requires in_valid sampled 0 for at least 1 cycle and then 1 in IDLE.
REQ-021 SHALL allow back-to-back sets; the minimum gap between the last sample and the next first sample is 2 cycles.
REQ-022 SHALL have no combinational path from inputs to outputs; out_valid and out_n are registered.

Reset
REQ-023 SHALL, on rst_n=0 at any time (including mid-COLLECT or OUT), immediately clear:
- FSM to IDLE;
- count, sorted array and latched mode to 0;
- out_valid=0, out_n=0.
REQ-024 SHALL process no partial set after rst_n rises; operation restarts from IDLE.

Verification
Set S is samples (W,V_GS,V_DS): (3,1,2),(3,4,1),(6,2,5),(7,7,7),(1,3,3),(5,5,2).
REQ-025 SHALL cover: 6 samples (7,7,7), mode=11 -> out_n=84, out_valid one cycle after the 6th sample.
REQ-026 SHALL cover: S with mode=00 -> out_n=1 (gm 0,2,4,28,1,6); S with mode=10 -> out_n=12.
REQ-027 SHALL cover: S with mode=11 -> out_n=29 (Id 0,5,2,84,1,20); S with mode=01 -> out_n=0.
REQ-028 SHALL cover: 3 samples, in_valid low, then full S with mode=11 -> exactly one out_valid, out_n=29.
REQ-029 SHALL cover: rst_n pulsed low after 4 samples of S -> outputs 0, no out_valid; next full S with mode=10 -> out_n=12.
REQ-030 SHALL cover: two sets at minimum gap (S mode=11, then S mode=00) -> out_n=29 then 1, each out_valid a single-cycle pulse.

Source files
------------

// File: rtl/smc_seq.sv
// smc_seq: collects six transistor samples, keeps them sorted and averages three
// Ports: clk, rst_n (async, active-low); in_valid, mode[1:0], W, V_GS, V_DS (sample in);
//        out_valid (one-cycle pulse), out_n[7:0] (result, 0 when out_valid=0)
module smc_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic [2:0] W,
  input  logic [2:0] V_GS,
  input  logic [2:0] V_DS,
  output logic       out_valid,
  output logic [7:0] out_n
);
  typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;
  state_t state, state_nx;
  logic armed, first, take, id_sel, triode;
  logic [2:0] cnt, vov;
  logic [1:0] mode_q;
  logic [6:0] arr [6];
  logic [6:0] base [6];
  logic [6:0] ins [6];
  logic [6:0] val, a, b, c;
  logic [9:0] id_p, gm_p, sum;
  logic [7:0] res;
  always_comb begin
    first = state == IDLE;
    // a new set may only start after in_valid has been seen low
    take = in_valid && (state == COLLECT || (first && armed));
    id_sel = first ? mode[0] : mode_q[0];
    vov = V_GS - 3'd1;
    triode = V_DS < vov;
    id_p = triode ? 10'(W) * 10'(V_DS) * (10'd2 * 10'(vov) - 10'(V_DS)) : 10'(W) * 10'(vov) * 10'(vov);
    gm_p = 10'd2 * 10'(W) * (triode ? 10'(V_DS) : 10'(vov));
    val = V_GS <= 3'd1 ? 7'd0 : 7'((id_sel ? id_p : gm_p) / 10'd3);
    // first sample inserts into an all-zero array, discarding any earlier set
    for (int i = 0; i < 6; i++) base[i] = first ? 7'd0 : arr[i];
    ins[0] = val > base[0] ? val : base[0];
    for (int i = 1; i < 6; i++) ins[i] = val > base[i-1] ? base[i-1] : val > base[i] ? val : base[i];
  end
  always_comb begin
    state_nx = state == IDLE ? (take ? COLLECT : IDLE) :
               state == COLLECT ? (!in_valid ? IDLE : cnt == 3'd5 ? OUT : COLLECT) : IDLE;
    a = mode_q[1] ? arr[0] : arr[3];
    b = mode_q[1] ? arr[1] : arr[4];
    c = mode_q[1] ? arr[2] : arr[5];
    sum = mode_q[0] ? 10'd3 * 10'(a) + 10'd4 * 10'(b) + 10'd5 * 10'(c) : 10'(a) + 10'(b) + 10'(c);
    res = 8'(mode_q[0] ? sum / 10'd12 : sum / 10'd3);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      cnt <= 3'd0;
      mode_q <= 2'd0;
      arr <= '{default: '0};
      out_valid <= 1'b0;
      out_n <= 8'd0;
    end else begin
      armed <= !in_valid;
      out_valid <= state == OUT;
      out_n <= state == OUT ? res : 8'd0;
      if (take) begin
        arr <= ins;
        cnt <= first ? 3'd1 : cnt == 3'd5 ? 3'd0 : cnt + 3'd1;
        if (first) mode_q <= mode;
      end
    end
  end
endmodule

// File: tb/tb_smc_seq.sv
// tb_smc_seq: directed and random stimulus checked per cycle against a behavioural model
module tb_smc_seq;
  logic clk = 0, rst_n = 1, in_valid = 0;
  logic [1:0] mode = 0;
  logic [2:0] W = 0, V_GS = 0, V_DS = 0;
  logic out_valid;
  logic [7:0] out_n;
  smc_seq dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .W(W),
               .V_GS(V_GS), .V_DS(V_DS), .out_valid(out_valid), .out_n(out_n));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  bit run = 0;
  bit m_due, m_blk, m_low, exp_v;
  int m_n, m_res, exp_n;
  bit [1:0] m_mode;
  int m_vals[$];
  int got[$];
  int sw[6] = '{3, 3, 6, 7, 1, 5};
  int sg[6] = '{1, 4, 2, 7, 3, 5};
  int sd[6] = '{2, 1, 5, 7, 3, 2};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask
  function automatic int value(input int w, input int g, input int d, input bit id);
    int vov;
    if (g <= 1) return 0;
    vov = g - 1;
    if (d < vov) return id ? w * d * (2 * vov - d) / 3 : 2 * w * d / 3;
    return id ? w * vov * vov / 3 : 2 * w * vov / 3;
  endfunction
  function automatic int result(input int v[$], input bit [1:0] md);
    int s[$];
    int a, b, c;
    s = v;
    s.rsort();
    a = md[1] ? s[0] : s[3];
    b = md[1] ? s[1] : s[4];
    c = md[1] ? s[2] : s[5];
    return md[0] ? (3 * a + 4 * b + 5 * c) / 12 : (a + b + c) / 3;
  endfunction
  task automatic model_reset();
    m_due = 0; m_blk = 0; m_low = 0; m_n = 0; m_vals.delete(); exp_v = 0; exp_n = 0;
  endtask
  task automatic model_step(input bit iv, input bit [1:0] md, input int w, input int g, input int d);
    exp_v = m_due;
    exp_n = m_due ? m_res : 0;
    m_due = 0;
    if (m_n > 0) begin
      if (iv) begin
        m_vals.push_back(value(w, g, d, m_mode[0]));
        m_n++;
        if (m_n == 6) begin
          m_res = result(m_vals, m_mode);
          m_due = 1; m_blk = 1; m_n = 0;
        end
      end else m_n = 0;
    end else if (m_blk) m_blk = 0;
    else if (iv && m_low) begin
      m_mode = md;
      m_vals.delete();
      m_vals.push_back(value(w, g, d, md[0]));
      m_n = 1;
    end
    m_low = !iv;
  endtask
  always @(negedge clk) if (run) begin
    chk("out_valid", out_valid, exp_v);
    chk("out_n", out_n, exp_n);
    if (out_valid === 1'b1) got.push_back(out_n);
  end
  task automatic cyc(input bit iv, input bit [1:0] md, input int w, input int g, input int d);
    in_valid = iv; mode = md; W = 3'(w); V_GS = 3'(g); V_DS = 3'(d);
    @(posedge clk);
    if (rst_n) model_step(iv, md, w, g, d);
    else model_reset();
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 2'($urandom), 0, 0, 0);
  endtask
  task automatic set_s(input bit [1:0] md, input int k);
    for (int i = 0; i < k; i++) cyc(1, i == 0 ? md : 2'($urandom), sw[i], sg[i], sd[i]);
  endtask
  task automatic rst_pulse();
    #2 rst_n = 0;
    model_reset();
    #1 chk("rst_out_valid", out_valid, 0);
    chk("rst_out_n", out_n, 0);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1;
  endtask
  task automatic pin(input string nm, input int n0, input int req);
    chk({nm, "_pulses"}, got.size() - n0, 1);
    chk(nm, got.size() > n0 ? got[$] : -1, req);
  endtask
  initial begin
    int n0;
    #1 rst_n = 0;
    model_reset();
    run = 1;
    idle(2);
    rst_n = 1;
    idle(2);
    n0 = got.size(); repeat (6) cyc(1, 3, 7, 7, 7); idle(3); pin("id777", n0, 84);
    n0 = got.size(); set_s(0, 6); idle(3); pin("gm_small", n0, 1);
    n0 = got.size(); set_s(2, 6); idle(3); pin("gm_large", n0, 12);
    n0 = got.size(); set_s(3, 6); idle(3); pin("id_large", n0, 29);
    n0 = got.size(); set_s(1, 6); idle(3); pin("id_small", n0, 0);
    n0 = got.size(); set_s(3, 3); idle(1); set_s(3, 6); idle(3); pin("abort", n0, 29);
    n0 = got.size(); set_s(2, 4); rst_pulse(); idle(1); set_s(2, 6); idle(3); pin("reset_mid", n0, 12);
    n0 = got.size(); set_s(3, 6); idle(1); set_s(0, 6); idle(3);
    chk("b2b_pulses", got.size() - n0, 2);
    chk("b2b_first", got.size() > n0 ? got[n0] : -1, 29);
    chk("b2b_second", got.size() > n0 + 1 ? got[n0 + 1] : -1, 1);
    n0 = got.size(); set_s(3, 6); repeat (3) cyc(1, 0, 7, 7, 7); idle(3); pin("held", n0, 29);
    set_s(3, 6); idle(1); rst_pulse(); idle(2);
    for (int k = 0; k < 600; k++)
      if ($urandom_range(0, 199) == 0) rst_pulse();
      else cyc($urandom_range(0, 9) != 0, 2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
